vga_scan_compositor: RTL and testbench

//  Pixel-scan master for the VGA output path. It generates the x/y scan position consumed by all

---
 rtl/vga_scan_compositor_pkg.sv | 58 +++++
 rtl/vga_scan_compositor_palette.sv | 26 ++
 rtl/vga_scan_compositor.sv | 159 +++++++++++++++
 tb/tb_vga_scan_compositor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_scan_compositor_pkg.sv
// Shared types and constants for the VGA scan/composite path: colour codes,
// RGB palette values, default 640x480@60 timing and pipeline flag bundle.
package vga_scan_compositor_pkg;

    typedef logic [2:0] color_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Colour codes returned by the draw layers
    localparam color_t C_EMPTY  = 3'd0;
    localparam color_t C_BORDER = 3'd1;
    localparam color_t C_CYAN   = 3'd2;
    localparam color_t C_BLUE   = 3'd3;
    localparam color_t C_ORANGE = 3'd4;
    localparam color_t C_YELLOW = 3'd5;
    localparam color_t C_GREEN  = 3'd6;
    localparam color_t C_RED    = 3'd7;

    // Palette values; empty is a dark navy so it is distinguishable from blanking
    localparam rgb_t RGB_EMPTY  = 24'h101020;
    localparam rgb_t RGB_BORDER = 24'h808080;
    localparam rgb_t RGB_CYAN   = 24'h00FFFF;
    localparam rgb_t RGB_BLUE   = 24'h0000FF;
    localparam rgb_t RGB_ORANGE = 24'hFFA500;
    localparam rgb_t RGB_YELLOW = 24'hFFFF00;
    localparam rgb_t RGB_GREEN  = 24'h00FF00;
    localparam rgb_t RGB_RED    = 24'hFF0000;

    // Default 640x480 timing, in pixel clocks / lines
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    // Per-pixel flags carried alongside the draw latency
    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
    } scan_flags_t;

    localparam scan_flags_t FLAGS_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

    // True when lo <= v < hi
    function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo,
                                     input logic [10:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_scan_compositor_palette.sv
// Colour-code to 24-bit RGB lookup; purely combinational so it can be shared
// by any block that needs to render a color_t.
module vga_scan_compositor_palette
    import vga_scan_compositor_pkg::*;
(
    input  color_t color,
    output rgb_t   rgb
);

    // Fixed LUT from colour code to RGB
    always_comb begin
        rgb = RGB_EMPTY;
        case (color)
            C_EMPTY:  rgb = RGB_EMPTY;
            C_BORDER: rgb = RGB_BORDER;
            C_CYAN:   rgb = RGB_CYAN;
            C_BLUE:   rgb = RGB_BLUE;
            C_ORANGE: rgb = RGB_ORANGE;
            C_YELLOW: rgb = RGB_YELLOW;
            C_GREEN:  rgb = RGB_GREEN;
            C_RED:    rgb = RGB_RED;
            default:  rgb = RGB_EMPTY;
        endcase
    end

endmodule

// File: rtl/vga_scan_compositor.sv
// VGA scan master: generates x/y for the draw layers, composites their
// replies by priority, maps through the palette and drives the DAC pins with
// sync/blank aligned to the pixel data.
module vga_scan_compositor
    import vga_scan_compositor_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
    parameter int unsigned H_FP         = VGA_H_FP,
    parameter int unsigned H_SYNC       = VGA_H_SYNC,
    parameter int unsigned H_BP         = VGA_H_BP,
    parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
    parameter int unsigned V_FP         = VGA_V_FP,
    parameter int unsigned V_SYNC       = VGA_V_SYNC,
    parameter int unsigned V_BP         = VGA_V_BP,
    parameter int unsigned N_LAYERS     = 4,
    parameter int unsigned DRAW_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic [10:0]            x,
    output logic [10:0]            y,
    input  color_t [N_LAYERS-1:0]  layer_color,
    input  logic [N_LAYERS-1:0]    layer_en,
    output logic                   frame_start,
    output logic [7:0]             vga_r,
    output logic [7:0]             vga_g,
    output logic [7:0]             vga_b,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   vga_blank_n,
    output logic                   vga_sync_n
);

    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [10:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic        run_q, run_d;
    logic        frame_start_q, frame_start_d;

    scan_flags_t                    flags0;
    scan_flags_t [DRAW_LATENCY-1:0] flag_pipe_q, flag_pipe_d;
    scan_flags_t                    flags_dl;

    color_t comp_color;
    logic   comp_found;
    rgb_t   pal_rgb;

    rgb_t rgb_q, rgb_d;
    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic blank_n_q, blank_n_d;

    // Scan counters; held at 0,0 for the first edge after reset so that
    // edge presents pixel 0,0 together with frame_start.
    always_comb begin
        run_d  = 1'b1;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (run_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 11'd1;
            end else begin
                hcnt_d = hcnt_q + 11'd1;
            end
        end
        frame_start_d = (hcnt_d == '0) && (vcnt_d == '0);
    end

    // Stage-0 flags; idle until the counters are actually scanning
    always_comb begin
        flags0 = FLAGS_IDLE;
        if (run_q) begin
            flags0.active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
            flags0.hs_n   = !in_span(hcnt_q, H_SS, H_SE);
            flags0.vs_n   = !in_span(vcnt_q, V_SS, V_SE);
        end
    end

    // Delay flags by the draw latency so they line up with the layer replies
    always_comb begin
        flag_pipe_d[0] = flags0;
        for (int unsigned i = 1; i < DRAW_LATENCY; i++) begin
            flag_pipe_d[i] = flag_pipe_q[i-1];
        end
    end

    assign flags_dl = flag_pipe_q[DRAW_LATENCY-1];

    // Priority composite: lowest enabled layer index wins
    always_comb begin
        comp_color = C_EMPTY;
        comp_found = 1'b0;
        for (int unsigned i = 0; i < N_LAYERS; i++) begin
            if (!comp_found && layer_en[i]) begin
                comp_color = layer_color[i];
                comp_found = 1'b1;
            end
        end
    end

    vga_scan_compositor_palette u_palette (
        .color (comp_color),
        .rgb   (pal_rgb)
    );

    // Output stage: force black outside the active area, register sync/blank
    always_comb begin
        rgb_d     = flags_dl.active ? pal_rgb : '0;
        hs_d      = flags_dl.hs_n;
        vs_d      = flags_dl.vs_n;
        blank_n_d = flags_dl.active;
    end

    // State registers, asynchronously cleared to the blanked idle state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            run_q         <= 1'b0;
            frame_start_q <= 1'b0;
            flag_pipe_q   <= {DRAW_LATENCY{FLAGS_IDLE}};
            rgb_q         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            run_q         <= run_d;
            frame_start_q <= frame_start_d;
            flag_pipe_q   <= flag_pipe_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
        end
    end

    assign x           = hcnt_q;
    assign y           = vcnt_q;
    assign frame_start = frame_start_q;
    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scan_compositor.sv
// Bench for vga_scan_compositor: a default-timing instance checked pixel by
// pixel through a latency scoreboard, plus a shrunken-timing instance used to
// observe whole frames within a short run.
module tb_vga_scan_compositor;
    import vga_scan_compositor_pkg::*;

    localparam int H_T  = 800;
    localparam int V_T  = 525;
    localparam int H_A  = 640;
    localparam int V_A  = 480;
    localparam int SH_T = 25;
    localparam int SV_T = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [10:0]      x, y;
    color_t [3:0]     layer_color;
    logic [3:0]       layer_en;
    logic             frame_start;
    logic [7:0]       vga_r, vga_g, vga_b;
    logic             vga_hs, vga_vs, vga_blank_n, vga_sync_n;

    logic [10:0]      x_s, y_s;
    color_t [3:0]     layer_color_s;
    logic [3:0]       layer_en_s;
    logic             frame_start_s;
    logic [7:0]       r_s, g_s, b_s;
    logic             hs_s, vs_s, blank_n_s, sync_n_s;

    vga_scan_compositor dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y),
        .layer_color(layer_color), .layer_en(layer_en), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n)
    );

    vga_scan_compositor #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut_s (
        .clk(clk), .reset_n(reset_n), .x(x_s), .y(y_s),
        .layer_color(layer_color_s), .layer_en(layer_en_s), .frame_start(frame_start_s),
        .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .vga_hs(hs_s), .vga_vs(vs_s),
        .vga_blank_n(blank_n_s), .vga_sync_n(sync_n_s)
    );

    typedef struct {
        logic [3:0]   en;
        color_t [3:0] col;
        int           exp_idx;
    } vec_t;

    typedef struct {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank_n;
    } exp_t;

    vec_t        vec [9];
    vec_t        cur;
    logic [23:0] pal_m [8];
    exp_t        sb [$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int   mx, my, sx, sy;
    logic started;
    logic [3:0]   nxt_en;
    color_t [3:0] nxt_col;

    int   x0_cyc, hs_fall_cyc, sfs_cyc, vs_fall_cyc;
    logic x0_ok, hs_fall_ok, sfs_ok, vs_fall_ok, hs_prev, vs_s_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, 32'(x), 32'd0);
        chk({tag, "_y"}, 32'(y), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk({tag, "_hs"}, 32'(vga_hs), 32'd1);
        chk({tag, "_vs"}, 32'(vga_vs), 32'd1);
        chk({tag, "_blank_n"}, 32'(vga_blank_n), 32'd0);
        chk({tag, "_sync_n"}, 32'(vga_sync_n), 32'd0);
        chk({tag, "_s_xy"}, 32'({x_s, y_s}), 32'd0);
        chk({tag, "_s_pins"}, 32'({r_s, g_s, b_s, hs_s, vs_s, blank_n_s, sync_n_s}), 32'd12);
    endtask

    task automatic reset_model();
        exp_t idle;
        idle = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, blank_n: 1'b0};
        started = 1'b0;
        mx = 0; my = 0; sx = 0; sy = 0;
        sb.delete();
        sb.push_back(idle);
        sb.push_back(idle);
        nxt_en = '0;
        nxt_col = '0;
        x0_ok = 1'b0; hs_fall_ok = 1'b0; sfs_ok = 1'b0; vs_fall_ok = 1'b0;
        hs_prev = 1'b1; vs_s_prev = 1'b1;
    endtask

    task automatic step();
        exp_t e, o;
        logic act;
        @(posedge clk);
        #1;
        cyc++;
        if (started) begin
            if (mx == H_T - 1) begin mx = 0; my = (my == V_T - 1) ? 0 : my + 1; end
            else mx++;
            if (sx == SH_T - 1) begin sx = 0; sy = (sy == SV_T - 1) ? 0 : sy + 1; end
            else sx++;
        end
        started = 1'b1;
        // registered draw-layer reply for the pixel presented last cycle
        layer_en = nxt_en;
        layer_color = nxt_col;

        chk("x", 32'(x), mx);
        chk("y", 32'(y), my);
        chk("frame_start", 32'(frame_start), 32'(mx == 0 && my == 0));
        chk("x_s", 32'(x_s), sx);
        chk("y_s", 32'(y_s), sy);
        chk("frame_start_s", 32'(frame_start_s), 32'(sx == 0 && sy == 0));

        nxt_en = cur.en;
        nxt_col = cur.col;
        act = (mx < H_A) && (my < V_A);
        e.rgb = act ? pal_m[cur.exp_idx] : 24'h0;
        e.hs = !(mx >= 656 && mx < 752);
        e.vs = !(my >= 490 && my < 492);
        e.blank_n = act;
        sb.push_back(e);
        if (sb.size() > 2) begin
            o = sb.pop_front();
            chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(o.rgb));
            chk("vga_hs", 32'(vga_hs), 32'(o.hs));
            chk("vga_vs", 32'(vga_vs), 32'(o.vs));
            chk("vga_blank_n", 32'(vga_blank_n), 32'(o.blank_n));
        end

        if (x == 11'd0) begin
            if (x0_ok) chk("line_period", cyc - x0_cyc, 800);
            x0_cyc = cyc;
            x0_ok = 1'b1;
        end
        if (!vga_hs && hs_prev) begin
            if (x0_ok) chk("hs_start", cyc - x0_cyc, 658);
            hs_fall_cyc = cyc;
            hs_fall_ok = 1'b1;
        end
        if (vga_hs && !hs_prev && hs_fall_ok) chk("hs_width", cyc - hs_fall_cyc, 96);
        hs_prev = vga_hs;

        if (frame_start_s) begin
            if (sfs_ok) chk("frame_period_s", cyc - sfs_cyc, SH_T * SV_T);
            sfs_cyc = cyc;
            sfs_ok = 1'b1;
        end
        if (!vs_s && vs_s_prev && sfs_ok) begin
            chk("vs_start_s", cyc - sfs_cyc, 7 * SH_T + 2);
            vs_fall_cyc = cyc;
            vs_fall_ok = 1'b1;
        end
        if (vs_s && !vs_s_prev && vs_fall_ok) chk("vs_width_s", cyc - vs_fall_cyc, 2 * SH_T);
        vs_s_prev = vs_s;
    endtask

    initial begin
        pal_m = '{24'h101020, 24'h808080, 24'h00FFFF, 24'h0000FF,
                  24'hFFA500, 24'hFFFF00, 24'h00FF00, 24'hFF0000};
        vec[0] = '{4'b0110, {3'd2, 3'd7, C_BORDER, 3'd3}, 1};
        vec[1] = '{4'b0000, {3'd5, 3'd4, 3'd3, 3'd2}, 0};
        vec[2] = '{4'b1111, {3'd1, 3'd2, 3'd3, 3'd5}, 5};
        vec[3] = '{4'b1000, {3'd4, 3'd6, 3'd6, 3'd6}, 4};
        vec[4] = '{4'b0100, {3'd1, 3'd7, 3'd1, 3'd1}, 7};
        vec[5] = '{4'b1010, {3'd3, 3'd2, 3'd6, 3'd5}, 6};
        vec[6] = '{4'b0001, {3'd7, 3'd7, 3'd7, 3'd2}, 2};
        vec[7] = '{4'b1100, {3'd5, 3'd3, 3'd1, 3'd1}, 3};
        vec[8] = '{4'b1111, {3'd6, 3'd6, 3'd6, 3'd6}, 6};

        reset_n = 1'b0;
        layer_en = '0;
        layer_color = '0;
        layer_en_s = '0;
        layer_color_s = '0;
        cur = vec[1];
        reset_model();

        repeat (5) begin
            @(negedge clk);
            chk_reset_vals("reset");
        end
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cur = vec[i];
            repeat (40) step();
        end

        // remaining active pixels, then blanking with every layer enabled
        cur = vec[8];
        for (int g = 0; g < 2000 && !(mx == 300 && my == 1); g++) step();
        chk("reach_x300", 32'(x), 32'd300);
        chk("reach_y1", 32'(y), 32'd1);

        #2 reset_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        repeat (3) begin
            @(negedge clk);
            chk_reset_vals("reset_hold");
        end
        reset_model();
        cur = vec[2];
        reset_n = 1'b1;
        repeat (1700) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
